// File: rtl/char_rotator_ctrl_if.sv
// char_rotator_ctrl_if: control, message-write and display-window signals of the character rotator
interface char_rotator_ctrl_if;
  logic       start, stop, pause, dir, wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ack, running, tick;
  logic [1:0] code2, code1, code0;
  logic [2:0] offset;
  modport master (
    output start, stop, pause, dir, wr_en, wr_addr, wr_data,
    input  wr_ack, code2, code1, code0, offset, running, tick
  );
  modport slave (
    input  start, stop, pause, dir, wr_en, wr_addr, wr_data,
    output wr_ack, code2, code1, code0, offset, running, tick
  );
endinterface

// File: rtl/char_rotator_ctrl.sv
// char_rotator_ctrl: rotates a three-character window through an 8-slot message buffer on a programmable timebase
module char_rotator_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MSG_LEN  = 5
) (
  input logic               clk,
  input logic               rst,
  char_rotator_ctrl_if.slave s
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [2:0] LAST = 3'(MSG_LEN - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [2:0]    offset, offset_n, o1, o2;
  logic [1:0]    msg [8];
  logic          accept, tick, wr_ack;
  always_comb begin
    tick     = state == RUN && !s.pause && !s.stop && presc == PMAX;
    accept   = state == IDLE && s.wr_en && s.wr_addr <= LAST;
    state_n  = s.stop ? IDLE
             : state == IDLE ? (s.start ? RUN : IDLE)
             : (s.pause ? PAUSE : RUN);
    presc_n  = (s.stop || state == IDLE) ? '0
             : (state == RUN && !s.pause) ? (tick ? '0 : presc + 1'b1)
             : presc;
    offset_n = s.stop ? '0
             : !tick ? offset
             : s.dir ? (offset == '0 ? LAST : offset - 1'b1)
             : (offset == LAST ? '0 : offset + 1'b1);
    o1       = offset == LAST ? '0 : offset + 1'b1;
    o2       = o1 == LAST ? '0 : o1 + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      offset <= '0;
      wr_ack <= 1'b0;
      for (int i = 0; i < 8; i++) msg[i] <= i < 3 ? 2'(i) : 2'b11;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      offset <= offset_n;
      wr_ack <= accept;
      if (accept) msg[s.wr_addr] <= s.wr_data;
    end
  end
  assign s.code2   = msg[offset];
  assign s.code1   = msg[o1];
  assign s.code0   = msg[o2];
  assign s.offset  = offset;
  assign s.running = state != IDLE;
  assign s.tick    = tick;
  assign s.wr_ack  = wr_ack;
endmodule

// File: tb/tb_char_rotator_ctrl.sv
// tb_char_rotator_ctrl: directed and randomized checks of the rotator against a cycle-level behavioural model
module tb_char_rotator_ctrl;
  localparam int TD = 4;
  localparam int ML = 5;
  logic clk, rst;
  char_rotator_ctrl_if ifc ();
  char_rotator_ctrl #(.TICK_DIV(TD), .MSG_LEN(ML)) dut (.clk(clk), .rst(rst), .s(ifc.slave));
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  // model: 0 idle, 1 run, 2 paused; cnt is cycles elapsed in the current rotation step
  int m_state = 0, m_cnt = 0, m_off = 0, m_ack = 0;
  int m_buf [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
  logic exp_tick, acc;
  assign exp_tick = m_state == 1 && !ifc.pause && !ifc.stop && m_cnt == TD - 1;
  assign acc = m_state == 0 && ifc.wr_en && int'(ifc.wr_addr) < ML;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pin_codes(input string name, input int c2, input int c1, input int c0);
    check({name, ".code2"}, int'(ifc.code2), c2);
    check({name, ".code1"}, int'(ifc.code1), c1);
    check({name, ".code0"}, int'(ifc.code0), c0);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_cnt <= 0;
      m_off <= 0;
      m_ack <= 0;
      for (int i = 0; i < 8; i++) m_buf[i] <= i < 3 ? i : 3;
    end else begin
      m_ack <= int'(acc);
      if (acc) m_buf[ifc.wr_addr] <= int'(ifc.wr_data);
      if (ifc.stop) begin
        m_state <= 0;
        m_cnt <= 0;
        m_off <= 0;
      end else begin
        if (exp_tick) m_off <= ifc.dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
        case (m_state)
          0: begin
            m_cnt <= 0;
            if (ifc.start) m_state <= 1;
          end
          1: if (ifc.pause) m_state <= 2; else m_cnt <= (m_cnt + 1) % TD;
          default: if (!ifc.pause) m_state <= 1;
        endcase
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("m.code2", int'(ifc.code2), m_buf[m_off]);
      check("m.code1", int'(ifc.code1), m_buf[(m_off + 1) % ML]);
      check("m.code0", int'(ifc.code0), m_buf[(m_off + 2) % ML]);
      check("m.offset", int'(ifc.offset), m_off);
      check("m.running", int'(ifc.running), int'(m_state != 0));
      check("m.tick", int'(ifc.tick), int'(exp_tick));
      check("m.wr_ack", int'(ifc.wr_ack), m_ack);
    end
  end
  initial begin
    int fwd [5];
    fwd = '{6'b01_10_11, 6'b10_11_11, 6'b11_11_00, 6'b11_00_01, 6'b00_01_10};
    {ifc.start, ifc.stop, ifc.pause, ifc.dir, ifc.wr_en} = '0;
    ifc.wr_addr = '0;
    ifc.wr_data = '0;
    rst = 1;
    step();
    chk_en = 1;
    step();
    rst = 0;
    @(negedge clk);
    pin_codes("reset", 0, 1, 2);
    check("reset.offset", int'(ifc.offset), 0);
    check("reset.running", int'(ifc.running), 0);
    check("reset.tick", int'(ifc.tick), 0);
    check("reset.wr_ack", int'(ifc.wr_ack), 0);
    step();
    ifc.start = 1;
    step();
    ifc.start = 0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      check("fwd.tick", int'(ifc.tick), int'(n % 4 == 0));
      if (n > 1 && (n - 1) % 4 == 0) begin
        int e;
        e = fwd[(n - 1) / 4 - 1];
        pin_codes("fwd", (e >> 4) & 3, (e >> 2) & 3, e & 3);
      end
    end
    check("fwd.offset_wrap", int'(ifc.offset), 0);
    step();
    ifc.stop = 1;
    step();
    ifc.stop = 0;
    ifc.dir = 1;
    ifc.start = 1;
    step();
    ifc.start = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("rev.tick", int'(ifc.tick), int'(n == 4));
    end
    check("rev.offset", int'(ifc.offset), 4);
    pin_codes("rev", 3, 0, 1);
    step();
    step();
    ifc.pause = 1;
    repeat (10) begin
      @(negedge clk);
      check("pause.tick", int'(ifc.tick), 0);
      check("pause.running", int'(ifc.running), 1);
    end
    step();
    ifc.pause = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("release.tick", int'(ifc.tick), int'(n == 2));
    end
    @(negedge clk);
    check("release.offset", int'(ifc.offset), 3);
    step();
    ifc.wr_en = 1;
    ifc.wr_addr = 3;
    ifc.wr_data = 2'b01;
    step();
    ifc.wr_en = 0;
    @(negedge clk);
    check("run_write.wr_ack", int'(ifc.wr_ack), 0);
    step();
    ifc.stop = 1;
    step();
    ifc.stop = 0;
    ifc.wr_en = 1;
    step();
    ifc.wr_en = 0;
    @(negedge clk);
    check("idle_write.wr_ack", int'(ifc.wr_ack), 1);
    check("idle_write.running", int'(ifc.running), 0);
    step();
    ifc.dir = 0;
    ifc.start = 1;
    step();
    ifc.start = 0;
    repeat (4) step();
    @(negedge clk);
    check("written.offset", int'(ifc.offset), 1);
    pin_codes("written", 1, 2, 1);
    step();
    ifc.stop = 1;
    step();
    ifc.stop = 0;
    ifc.wr_en = 1;
    ifc.wr_addr = 6;
    ifc.wr_data = 2'b00;
    step();
    ifc.wr_en = 0;
    @(negedge clk);
    check("addr6.wr_ack", int'(ifc.wr_ack), 0);
    step();
    ifc.start = 1;
    ifc.stop = 1;
    step();
    ifc.start = 0;
    ifc.stop = 0;
    @(negedge clk);
    check("start_stop.running", int'(ifc.running), 0);
    step();
    step();
    @(negedge clk);
    check("start_stop.tick", int'(ifc.tick), 0);
    step();
    ifc.start = 1;
    step();
    ifc.start = 0;
    repeat (12) step();
    @(negedge clk);
    check("midrun.offset", int'(ifc.offset), 3);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("midreset.offset", int'(ifc.offset), 0);
    check("midreset.running", int'(ifc.running), 0);
    pin_codes("midreset", 0, 1, 2);
    step();
    ifc.start = 1;
    step();
    ifc.start = 0;
    repeat (4) step();
    @(negedge clk);
    pin_codes("restored", 1, 2, 3);
    repeat (600) begin
      step();
      ifc.start = $urandom_range(0, 7) == 0;
      ifc.stop = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 15) == 0) ifc.pause = ~ifc.pause;
      ifc.dir = 1'($urandom_range(0, 1));
      ifc.wr_en = $urandom_range(0, 2) == 0;
      ifc.wr_addr = 3'($urandom_range(0, 7));
      ifc.wr_data = 2'($urandom_range(0, 3));
      rst = $urandom_range(0, 149) == 0;
    end
    step();
    rst = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
